// File: rtl/rfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rfile_pkg
// Brief    : Shared types and helpers for the multi-port register file.
// Revision : 1.0 - initial release
// ============================================================================
package rfile_pkg;

    typedef enum logic {RF_IDLE = 1'b0, RF_CLEAR = 1'b1} rfile_state_t;

    // Address width for an n-entry file; never below 1 so tiny files still get a port.
    function automatic int rf_aw(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rfile_clear_fsm.sv
`default_nettype none
// ============================================================================
// Module   : rfile_clear_fsm
// Brief    : Sequential zeroing engine; walks entries 1..NREGS-1 after reset
//            or a soft flush and raises busy while it runs.
// Revision : 1.0 - initial release
// ============================================================================
module rfile_clear_fsm
    import rfile_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = rf_aw(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] c_FIRST = AW'(1);
    localparam logic [AW-1:0] c_LAST  = AW'(NREGS - 1);

    rfile_state_t  r_state;
    rfile_state_t  w_state_nxt;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] w_ptr_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RF_CLEAR;
            r_ptr   <= c_FIRST;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        busy        = 1'b0;
        clr_we      = 1'b0;
        clr_addr    = r_ptr;
        case (r_state)
            RF_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = RF_CLEAR;
                    w_ptr_nxt   = c_FIRST;
                end
            end
            RF_CLEAR: begin
                busy      = 1'b1;
                // A reset edge must not itself modify storage.
                clr_we    = rst_n;
                w_ptr_nxt = r_ptr + c_FIRST;
                if (r_ptr == c_LAST) begin
                    w_state_nxt = RF_IDLE;
                end
            end
            default: w_state_nxt = RF_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_mp
// Brief    : Parametrised multi-port register file with hardwired-zero entry 0,
//            asynchronous reads and a sequential clear engine.
//            Define RFILE_BYPASS_EN to forward same-cycle write data to reads.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_mp
    import rfile_pkg::*;
#(
    parameter  int XLEN   = 32,
    parameter  int NREGS  = 32,
    parameter  int NREAD  = 2,
    parameter  int NWRITE = 1,
    localparam int AW     = rf_aw(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_req,
    output logic                   busy,
    input  logic [NREAD*AW-1:0]    r_addr,
    output logic [NREAD*XLEN-1:0]  r_data,
    input  logic [NWRITE-1:0]      w_en,
    input  logic [NWRITE*AW-1:0]   w_addr,
    input  logic [NWRITE*XLEN-1:0] w_data
);

    // Left without reset so it can map onto distributed RAM.
    logic [XLEN-1:0] r_mem [NREGS];

    logic            w_busy;
    logic            w_clr_we;
    logic [AW-1:0]   w_clr_addr;
    logic [NWRITE-1:0] w_wr_ok;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && (int'(a) < NREGS);
    endfunction

    rfile_clear_fsm #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (w_busy),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    assign busy = w_busy;

    generate
        for (genvar j = 0; j < NWRITE; j++) begin : g_wq
            assign w_wr_ok[j] = w_en[j] && !w_busy && addr_ok(w_addr[j*AW +: AW]);
        end
    endgenerate

    // Later ports overwrite earlier ones, so the highest port wins a collision.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else begin
            for (int j = 0; j < NWRITE; j++) begin
                if (w_wr_ok[j]) begin
                    r_mem[w_addr[j*AW +: AW]] <= w_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < NREAD; k++) begin : g_rd
            logic [AW-1:0]   w_ra;
            logic [XLEN-1:0] w_rv;

            assign w_ra = r_addr[k*AW +: AW];

            always_comb begin
                w_rv = '0;
                if (addr_ok(w_ra)) begin
                    w_rv = r_mem[w_ra];
                end
`ifdef RFILE_BYPASS_EN
                for (int j = 0; j < NWRITE; j++) begin
                    if (w_wr_ok[j] && (w_addr[j*AW +: AW] == w_ra)) begin
                        w_rv = w_data[j*XLEN +: XLEN];
                    end
                end
`endif
                if (w_busy) begin
                    w_rv = '0;
                end
            end

            assign r_data[k*XLEN +: XLEN] = w_rv;
        end
    endgenerate

endmodule
`default_nettype wire
